// File: rtl/rv32i_imem_loader.sv
// Loads a received program image into RV32I instruction memory word by word,
// verifies the word count against the frame length and releases the core on success.
module rv32i_imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_ip_p,
    input  logic              data_o_valid,
    input  logic [31:0]       icache_wr_data,
    input  logic [15:0]       prg_data_len,
    input  logic              rx_finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StRun,
        StErr
    } state_e;

    // Comparison width wide enough for both the word counter and the 17-bit expectation.
    localparam int unsigned       CmpW     = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [ADDR_W:0]   Capacity = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       len_q, len_d;

    logic [16:0]       expected_words;
    logic [31:0]       word_fmt;
    logic              has_room;
    logic              check_ok;

    always_comb begin
        expected_words = (17'(len_q) + 17'd3) >> 2;
        word_fmt       = (BYTE_SWAP != 0)
                       ? {icache_wr_data[7:0], icache_wr_data[15:8],
                          icache_wr_data[23:16], icache_wr_data[31:24]}
                       : icache_wr_data;
        has_room       = (cnt_q < Capacity);
        check_ok       = (CmpW'(cnt_q) == CmpW'(expected_words)) &&
                         (expected_words != 17'd0) && !ovf_q;
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        len_d   = len_q;

        unique case (state_q)
            StIdle: begin
                hold_d = 1'b1;
            end
            StLoad: begin
                // A restart from valid_ip_p drops any word and rx_finish in the same cycle.
                if (!valid_ip_p) begin
                    if (data_o_valid) begin
                        if (has_room) begin
                            we_d    = 1'b1;
                            addr_d  = BaseAddr + cnt_q[ADDR_W-1:0];
                            wdata_d = word_fmt;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (rx_finish) begin
                        state_d = StCheck;
                        len_d   = prg_data_len;
                    end
                end
            end
            StCheck: begin
                if (check_ok) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                end
            end
            StRun: begin
                hold_d = 1'b0;
                done_d = 1'b1;
            end
            StErr: begin
                hold_d = 1'b1;
                err_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
                hold_d  = 1'b1;
            end
        endcase

        if (valid_ip_p && (state_q != StCheck)) begin
            state_d = StLoad;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            len_q   <= len_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Drives three loader configurations (default, 4-word memory, byte-swapped with offset base)
// from one stimulus stream and checks each against a frame-level reference model.
module tb_rv32i_imem_loader;

    logic        clk = 1'b0;
    logic        rst, vip, dv, rxf;
    logic [31:0] data;
    logic [15:0] plen;

    always #5 clk = ~clk;

    logic        we0, we1, we2;
    logic [9:0]  a0, a2;
    logic [1:0]  a1;
    logic [31:0] d0, d1, d2;
    logic        h0, h1, h2, dn0, dn1, dn2, e0, e1, e2;
    logic [10:0] c0, c2;
    logic [2:0]  c1;

    rv32i_imem_loader #(.ADDR_W(10), .BASE_ADDR(0), .BYTE_SWAP(0)) dut0 (
        .clk(clk), .rst(rst), .valid_ip_p(vip), .data_o_valid(dv), .icache_wr_data(data),
        .prg_data_len(plen), .rx_finish(rxf), .imem_we(we0), .imem_addr(a0), .imem_wdata(d0),
        .cpu_hold(h0), .load_done(dn0), .load_err(e0), .word_cnt(c0));

    rv32i_imem_loader #(.ADDR_W(2), .BASE_ADDR(0), .BYTE_SWAP(0)) dut1 (
        .clk(clk), .rst(rst), .valid_ip_p(vip), .data_o_valid(dv), .icache_wr_data(data),
        .prg_data_len(plen), .rx_finish(rxf), .imem_we(we1), .imem_addr(a1), .imem_wdata(d1),
        .cpu_hold(h1), .load_done(dn1), .load_err(e1), .word_cnt(c1));

    rv32i_imem_loader #(.ADDR_W(10), .BASE_ADDR(1022), .BYTE_SWAP(1)) dut2 (
        .clk(clk), .rst(rst), .valid_ip_p(vip), .data_o_valid(dv), .icache_wr_data(data),
        .prg_data_len(plen), .rx_finish(rxf), .imem_we(we2), .imem_addr(a2), .imem_wdata(d2),
        .cpu_hold(h2), .load_done(dn2), .load_err(e2), .word_cnt(c2));

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 receiving, 2 verdict pending, 3 running, 4 failed.
    int          m_phase[3];
    int          m_cnt[3];
    int          m_len[3];
    bit          m_ovf[3], m_done[3], m_err[3], m_hold[3], m_we[3], m_bus[3];
    int          m_addr[3];
    logic [31:0] m_wdata[3];

    function automatic int cap_of(int i);
        return (i == 1) ? 4 : 1024;
    endfunction

    function automatic int base_of(int i);
        return (i == 2) ? 1022 : 0;
    endfunction

    function automatic logic [31:0] fmt(int i, logic [31:0] w);
        if (i == 2) return {w[7:0], w[15:8], w[23:16], w[31:24]};
        return w;
    endfunction

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            m_we[i]  = 0;
            m_bus[i] = 0;
            if (rst) begin
                m_phase[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0; m_err[i] = 0;
                m_hold[i] = 1; m_addr[i] = 0; m_wdata[i] = 0; m_bus[i] = 1;
            end else if (m_phase[i] == 2) begin
                if (m_cnt[i] == (m_len[i] + 3) / 4 && m_len[i] != 0 && !m_ovf[i]) begin
                    m_phase[i] = 3; m_done[i] = 1; m_hold[i] = 0;
                end else begin
                    m_phase[i] = 4; m_err[i] = 1; m_hold[i] = 1;
                end
            end else if (vip) begin
                m_phase[i] = 1; m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0; m_err[i] = 0;
                m_hold[i] = 1;
            end else if (m_phase[i] == 1) begin
                if (dv && m_cnt[i] < cap_of(i)) begin
                    m_we[i] = 1; m_bus[i] = 1;
                    m_addr[i] = (base_of(i) + m_cnt[i]) % cap_of(i);
                    m_wdata[i] = fmt(i, data);
                    m_cnt[i]++;
                end else if (dv) begin
                    m_ovf[i] = 1;
                end
                if (rxf) begin
                    m_phase[i] = 2; m_len[i] = int'(plen);
                end
            end
        end
    endtask

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        o_we, o_h, o_dn, o_e;
        logic [31:0] o_a, o_d, o_c;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin o_we = we0; o_a = 32'(a0); o_d = d0; o_h = h0; o_dn = dn0; o_e = e0;
                         o_c = 32'(c0); end
                1: begin o_we = we1; o_a = 32'(a1); o_d = d1; o_h = h1; o_dn = dn1; o_e = e1;
                         o_c = 32'(c1); end
                default: begin o_we = we2; o_a = 32'(a2); o_d = d2; o_h = h2; o_dn = dn2;
                         o_e = e2; o_c = 32'(c2); end
            endcase
            chk("imem_we", i, 32'(o_we), 32'(m_we[i]));
            if (m_bus[i]) begin
                chk("imem_addr", i, o_a, 32'(m_addr[i]));
                chk("imem_wdata", i, o_d, m_wdata[i]);
            end
            chk("cpu_hold", i, 32'(o_h), 32'(m_hold[i]));
            chk("load_done", i, 32'(o_dn), 32'(m_done[i]));
            chk("load_err", i, 32'(o_e), 32'(m_err[i]));
            chk("word_cnt", i, o_c, 32'(m_cnt[i]));
            chk("done_err_excl", i, 32'(o_dn & o_e), 32'd0);
        end
    endtask

    task automatic step(bit r, bit v, bit d, logic [31:0] w, bit f, logic [15:0] l);
        rst = r; vip = v; dv = d; data = w; rxf = f; plen = l;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 0, 16'h0);
    endtask

    // Frame of n words 0x13.. back-to-back; the last word optionally shares the rx_finish cycle.
    task automatic frame(int n, logic [15:0] len, bit last_with_finish);
        step(0, 1, 0, 32'h0, 0, 16'h0);
        for (int k = 0; k < n; k++) begin
            if (last_with_finish && k == n - 1) step(0, 0, 1, 32'h13 + 32'(k), 1, len);
            else step(0, 0, 1, 32'h13 + 32'(k), 0, 16'h0);
        end
        if (!last_with_finish || n == 0) step(0, 0, 0, 32'h0, 1, len);
        idle(2);
    endtask

    initial begin
        rst = 1; vip = 0; dv = 0; data = 0; rxf = 0; plen = 0;
        step(1, 0, 0, 32'h0, 0, 16'h0);
        step(1, 1, 1, 32'hdead_beef, 1, 16'd4);
        idle(2);

        frame(4, 16'd16, 0);
        frame(3, 16'd10, 0);
        frame(2, 16'd10, 0);
        frame(5, 16'd20, 0);
        frame(0, 16'd0, 0);

        step(0, 1, 0, 32'h0, 0, 16'h0);
        step(0, 0, 1, 32'h1122_3344, 0, 16'h0);
        step(0, 0, 1, 32'hA1B2_C3D4, 1, 16'd8);
        idle(2);

        step(0, 1, 0, 32'h0, 0, 16'h0);
        step(0, 0, 1, 32'h0000_0013, 0, 16'h0);
        step(0, 0, 1, 32'h0000_0014, 0, 16'h0);
        step(1, 0, 1, 32'h0000_0015, 0, 16'h0);
        step(0, 0, 1, 32'h0000_0016, 1, 16'd16);
        idle(2);

        frame(1, 16'd4, 1);
        step(0, 1, 0, 32'h0, 1, 16'd4);
        step(0, 0, 1, 32'h55, 0, 16'h0);
        step(0, 1, 1, 32'h66, 1, 16'd4);
        step(0, 0, 0, 32'h0, 1, 16'd0);
        idle(2);

        for (int f = 0; f < 40; f++) begin
            int n, len, k;
            n = int'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) begin
                len = n * 4 - int'($urandom_range(0, 3));
                if (len < 0) len = 0;
            end else begin
                len = int'($urandom_range(0, 30));
            end
            step(0, 1, 0, 32'h0, 0, 16'h0);
            k = 0;
            while (k < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(0, 0, 0, $urandom, 0, 16'($urandom));
                end else if ($urandom_range(0, 40) == 0) begin
                    step(0, 1, 1, $urandom, 0, 16'h0);
                    k = 0;
                end else begin
                    step($urandom_range(0, 60) == 0, 0, 1, $urandom,
                         (k == n - 1) && ($urandom_range(0, 1) == 1), 16'(len));
                    k++;
                end
            end
            step(0, 0, $urandom_range(0, 1) == 1, $urandom, 1, 16'(len));
            for (int g = 0; g < 3; g++)
                step(0, 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                     16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
